// File: rtl/alu_ctrl_fsm.sv
// rtl/alu_ctrl_fsm.sv - multicycle MIPS main controller driving ALU control and datapath selects
module alu_ctrl_fsm #(
  parameter int ALUCONTROL_WIDTH = 4,
  parameter int STATE_WIDTH      = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [5:0]                  opcode,
  input  logic [5:0]                  funct,
  input  logic                        zero,
  output logic [ALUCONTROL_WIDTH-1:0] alu_control,
  output logic                        alu_src_a,
  output logic [1:0]                  alu_src_b,
  output logic [1:0]                  pc_source,
  output logic                        pc_en,
  output logic                        i_or_d,
  output logic                        mem_read,
  output logic                        mem_write,
  output logic                        ir_write,
  output logic                        reg_dst,
  output logic                        mem_to_reg,
  output logic                        reg_write,
  output logic                        instr_done,
  output logic                        illegal
);

  typedef enum logic [STATE_WIDTH-1:0] {
    S_RESET,
    S_FETCH,
    S_DECODE,
    S_MEM_ADDR,
    S_MEM_READ,
    S_MEM_WB,
    S_MEM_WRITE,
    S_R_EXEC,
    S_R_WB,
    S_ADDI_WB,
    S_BRANCH,
    S_JUMP
  } state_t;

  // Memory-class op is latched in DECODE so MEM_ADDR never re-reads opcode.
  typedef enum logic [1:0] {
    MOP_NONE,
    MOP_LW,
    MOP_SW,
    MOP_ADDI
  } mem_op_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [ALUCONTROL_WIDTH-1:0] ALU_ADD = ALUCONTROL_WIDTH'(4'b0010);
  localparam logic [ALUCONTROL_WIDTH-1:0] ALU_SUB = ALUCONTROL_WIDTH'(4'b0110);
  localparam logic [ALUCONTROL_WIDTH-1:0] ALU_AND = ALUCONTROL_WIDTH'(4'b0000);
  localparam logic [ALUCONTROL_WIDTH-1:0] ALU_OR  = ALUCONTROL_WIDTH'(4'b0001);
  localparam logic [ALUCONTROL_WIDTH-1:0] ALU_SLT = ALUCONTROL_WIDTH'(4'b0111);

  state_t  state_q, state_d;
  mem_op_t mem_op_q, mem_op_d;
  logic    pc_write;
  logic    pc_write_cond;

  function automatic logic funct_ok(input logic [5:0] f);
    return (f == FN_ADD) || (f == FN_SUB) || (f == FN_AND) ||
           (f == FN_OR)  || (f == FN_SLT);
  endfunction

  function automatic logic [ALUCONTROL_WIDTH-1:0] funct_alu(input logic [5:0] f);
    logic [ALUCONTROL_WIDTH-1:0] r;
    r = '0;
    case (f)
      FN_ADD:  r = ALU_ADD;
      FN_SUB:  r = ALU_SUB;
      FN_AND:  r = ALU_AND;
      FN_OR:   r = ALU_OR;
      FN_SLT:  r = ALU_SLT;
      default: r = '0;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_RESET;
      mem_op_q <= MOP_NONE;
    end else begin
      state_q  <= state_d;
      mem_op_q <= mem_op_d;
    end
  end

  always_comb begin
    state_d       = S_FETCH;
    mem_op_d      = mem_op_q;
    alu_control   = '0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'd0;
    pc_source     = 2'd0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    instr_done    = 1'b0;
    illegal       = 1'b0;

    case (state_q)
      S_RESET: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        mem_read    = 1'b1;
        ir_write    = 1'b1;
        alu_src_b   = 2'd1;
        alu_control = ALU_ADD;
        pc_write    = 1'b1;
        state_d     = S_DECODE;
      end
      S_DECODE: begin
        // ALUOut captures PC+4 + (imm << 2) for a possible beq.
        alu_src_b   = 2'd3;
        alu_control = ALU_ADD;
        mem_op_d    = MOP_NONE;
        case (opcode)
          OP_RTYPE: begin
            if (funct_ok(funct)) state_d = S_R_EXEC;
            else                 illegal = 1'b1;
          end
          OP_LW: begin
            mem_op_d = MOP_LW;
            state_d  = S_MEM_ADDR;
          end
          OP_SW: begin
            mem_op_d = MOP_SW;
            state_d  = S_MEM_ADDR;
          end
          OP_ADDI: begin
            mem_op_d = MOP_ADDI;
            state_d  = S_MEM_ADDR;
          end
          OP_BEQ:  state_d = S_BRANCH;
          OP_J:    state_d = S_JUMP;
          default: illegal = 1'b1;
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a   = 1'b1;
        alu_src_b   = 2'd2;
        alu_control = ALU_ADD;
        case (mem_op_q)
          MOP_LW:   state_d = S_MEM_READ;
          MOP_SW:   state_d = S_MEM_WRITE;
          MOP_ADDI: state_d = S_ADDI_WB;
          default:  state_d = S_FETCH;
        endcase
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        state_d  = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_write  = 1'b1;
        i_or_d     = 1'b1;
        instr_done = 1'b1;
      end
      S_R_EXEC: begin
        alu_src_a   = 1'b1;
        alu_control = funct_alu(funct);
        state_d     = S_R_WB;
      end
      S_R_WB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
      end
      S_ADDI_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_control   = ALU_SUB;
        pc_source     = 2'd1;
        pc_write_cond = 1'b1;
        instr_done    = 1'b1;
      end
      S_JUMP: begin
        pc_source  = 2'd2;
        pc_write   = 1'b1;
        instr_done = 1'b1;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  assign pc_en = pc_write | (pc_write_cond & zero);

endmodule

// File: tb/tb_alu_ctrl_fsm.sv
// tb/tb_alu_ctrl_fsm.sv - self-checking bench for alu_ctrl_fsm against an instruction-level output model
module tb_alu_ctrl_fsm;

  typedef struct packed {
    logic [3:0] alu_control;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic       pc_en;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       instr_done;
    logic       illegal;
  } outs_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'b000000;
  logic [5:0] funct = 6'b100000;
  logic       zero = 1'b0;
  logic [3:0] alu_control;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_source;
  logic       pc_en, i_or_d, mem_read, mem_write, ir_write;
  logic       reg_dst, mem_to_reg, reg_write, instr_done, illegal;

  outs_t got;
  outs_t exp_q[$];
  int    n_checks = 0;
  int    n_fail = 0;

  alu_ctrl_fsm #(.ALUCONTROL_WIDTH(4), .STATE_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .alu_control(alu_control), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .pc_source(pc_source), .pc_en(pc_en), .i_or_d(i_or_d), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .instr_done(instr_done),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  assign got = {alu_control, alu_src_a, alu_src_b, pc_source, pc_en, i_or_d, mem_read,
                mem_write, ir_write, reg_dst, mem_to_reg, reg_write, instr_done, illegal};

  // Per-cycle output trace of one whole instruction, FETCH through its final cycle.
  task automatic model(input logic [5:0] op, input logic [5:0] fn, input logic z);
    outs_t e;
    logic [3:0] rcode;
    logic ill;
    exp_q.delete();
    e = '0; e.mem_read = 1; e.ir_write = 1; e.alu_src_b = 1; e.alu_control = 4'b0010; e.pc_en = 1;
    exp_q.push_back(e);
    ill = 1'b0;
    rcode = 4'b0000;
    if (op == 6'b000000) begin
      if      (fn == 6'b100000) rcode = 4'b0010;
      else if (fn == 6'b100010) rcode = 4'b0110;
      else if (fn == 6'b100100) rcode = 4'b0000;
      else if (fn == 6'b100101) rcode = 4'b0001;
      else if (fn == 6'b101010) rcode = 4'b0111;
      else ill = 1'b1;
    end else if (!(op inside {6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010})) begin
      ill = 1'b1;
    end
    e = '0; e.alu_src_b = 3; e.alu_control = 4'b0010; e.illegal = ill;
    exp_q.push_back(e);
    if (ill) return;
    if (op inside {6'b100011, 6'b101011, 6'b001000}) begin
      e = '0; e.alu_src_a = 1; e.alu_src_b = 2; e.alu_control = 4'b0010;
      exp_q.push_back(e);
    end
    e = '0;
    case (op)
      6'b100011: begin
        e.mem_read = 1; e.i_or_d = 1;
        exp_q.push_back(e);
        e = '0; e.reg_write = 1; e.mem_to_reg = 1; e.instr_done = 1;
      end
      6'b101011: begin e.mem_write = 1; e.i_or_d = 1; e.instr_done = 1; end
      6'b001000: begin e.reg_write = 1; e.instr_done = 1; end
      6'b000100: begin
        e.alu_src_a = 1; e.alu_control = 4'b0110; e.pc_source = 1; e.pc_en = z; e.instr_done = 1;
      end
      6'b000010: begin e.pc_source = 2; e.pc_en = 1; e.instr_done = 1; end
      default: begin
        e.alu_src_a = 1; e.alu_control = rcode;
        exp_q.push_back(e);
        e = '0; e.reg_write = 1; e.reg_dst = 1; e.instr_done = 1;
      end
    endcase
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #2;
      n_checks++;
      if (got !== outs_t'(0)) begin
        n_fail++; $display("FAIL reset[%0d]: got %05h expected %05h", c, got, 19'h0);
      end
    end
    rst_n = 1'b1;
    model(6'b000000, 6'b100000, 1'b0);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(posedge clk); #2;
      n_checks++;
      if (got !== exp_q[i]) begin
        n_fail++; $display("FAIL reset_then_add[%0d]: got %05h expected %05h", i, got, exp_q[i]);
      end
    end
  endtask

  task automatic test_lw();
    logic [5:0] ops[2];
    ops[0] = 6'b100011; ops[1] = 6'b000010;
    for (int k = 0; k < 2; k++) begin
      model(ops[k], 6'($urandom), 1'($urandom));
      for (int i = 0; i < exp_q.size(); i++) begin
        @(posedge clk); #1;
        if (i == 0) begin opcode = ops[k]; funct = 6'($urandom); zero = 1'($urandom); end
        #1;
        n_checks++;
        if (got !== exp_q[i]) begin
          n_fail++; $display("FAIL lw_then_j op%0d[%0d]: got %05h expected %05h", k, i, got, exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_rtype();
    logic [5:0] fns[5];
    fns[0] = 6'b100000; fns[1] = 6'b100010; fns[2] = 6'b100100; fns[3] = 6'b100101; fns[4] = 6'b101010;
    for (int k = 0; k < 5; k++) begin
      model(6'b000000, fns[k], 1'b0);
      for (int i = 0; i < exp_q.size(); i++) begin
        @(posedge clk); #1;
        if (i == 0) begin opcode = 6'b000000; funct = fns[k]; zero = 1'($urandom); end
        #1;
        n_checks++;
        if (got !== exp_q[i]) begin
          n_fail++; $display("FAIL rtype f%0d[%0d]: got %05h expected %05h", k, i, got, exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_beq();
    for (int k = 1; k >= 0; k--) begin
      model(6'b000100, 6'($urandom), 1'(k));
      for (int i = 0; i < exp_q.size(); i++) begin
        @(posedge clk); #1;
        if (i == 0) begin opcode = 6'b000100; funct = 6'($urandom); zero = 1'(k); end
        #1;
        n_checks++;
        if (got !== exp_q[i]) begin
          n_fail++; $display("FAIL beq z%0d[%0d]: got %05h expected %05h", k, i, got, exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_illegal();
    logic [5:0] ops[2];
    logic [5:0] fns[2];
    ops[0] = 6'b111111; fns[0] = 6'b100000;
    ops[1] = 6'b000000; fns[1] = 6'b000111;
    for (int k = 0; k < 2; k++) begin
      model(ops[k], fns[k], 1'b1);
      for (int i = 0; i < exp_q.size(); i++) begin
        @(posedge clk); #1;
        if (i == 0) begin opcode = ops[k]; funct = fns[k]; zero = 1'b1; end
        #1;
        n_checks++;
        if (got !== exp_q[i]) begin
          n_fail++; $display("FAIL illegal%0d[%0d]: got %05h expected %05h", k, i, got, exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    model(6'b101011, 6'b000000, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin opcode = 6'b101011; funct = 6'b000000; zero = 1'b1; end
      #1;
      n_checks++;
      if (got !== exp_q[i]) begin
        n_fail++; $display("FAIL sw_pre_reset[%0d]: got %05h expected %05h", i, got, exp_q[i]);
      end
    end
    rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #2;
      n_checks++;
      if (got !== outs_t'(0)) begin
        n_fail++; $display("FAIL mid_reset[%0d]: got %05h expected %05h", c, got, 19'h0);
      end
    end
    rst_n = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(posedge clk); #2;
      n_checks++;
      if (got !== exp_q[i]) begin
        n_fail++; $display("FAIL sw_after_reset[%0d]: got %05h expected %05h", i, got, exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] legal_ops[6];
    logic [5:0] r_fns[5];
    logic [5:0] op, fn;
    logic z;
    legal_ops[0] = 6'b000000; legal_ops[1] = 6'b100011; legal_ops[2] = 6'b101011;
    legal_ops[3] = 6'b000100; legal_ops[4] = 6'b001000; legal_ops[5] = 6'b000010;
    r_fns[0] = 6'b100000; r_fns[1] = 6'b100010; r_fns[2] = 6'b100100;
    r_fns[3] = 6'b100101; r_fns[4] = 6'b101010;
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 7))
        0:       begin op = 6'($urandom); fn = 6'($urandom); end
        1:       begin op = 6'b000000; fn = 6'($urandom); end
        default: begin op = legal_ops[$urandom_range(0, 5)]; fn = r_fns[$urandom_range(0, 4)]; end
      endcase
      z = 1'($urandom);
      model(op, fn, z);
      for (int i = 0; i < exp_q.size(); i++) begin
        @(posedge clk); #1;
        if (i == 0) begin opcode = op; funct = fn; zero = z; end
        #1;
        n_checks++;
        if (got !== exp_q[i]) begin
          n_fail++;
          $display("FAIL random#%0d op=%b fn=%b z=%0d [%0d]: got %05h expected %05h",
                   n, op, fn, z, i, got, exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_rtype();
    test_beq();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/alu_ctrl_fsm.md
Name: alu_ctrl_fsm

Overview:
- Multicycle main controller for the non-pipelined MIPS datapath. It is the initiator side of the ALU interface.
- Decodes opcode/funct, sequences fetch/decode/execute/memory/writeback, and drives alu_control and the datapath selects.
- Consumes the ALU zero flag to resolve beq.
- Sits between the instruction register and the datapath muxes, register file, memory and PC enable.

Parameters:
- ALUCONTROL_WIDTH, 4, width of alu_control; encodings below assume 4.
- STATE_WIDTH, 4, width of the internal state register.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- opcode  in  6  instruction[31:26] from the instruction register
- funct  in  6  instruction[5:0] from the instruction register
- zero  in  1  ALU zero flag (src1 == src2)
- alu_control  out  ALUCONTROL_WIDTH  ALU operation select
- alu_src_a  out  1  0 = PC, 1 = register A
- alu_src_b  out  2  0 = register B, 1 = constant 4, 2 = sign-extended imm, 3 = sign-extended imm << 2
- pc_source  out  2  0 = ALU result, 1 = ALUOut register, 2 = jump target
- pc_en  out  1  PC write enable
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- ir_write  out  1  instruction register load
- reg_dst  out  1  write register: 0 = rt, 1 = rd
- mem_to_reg  out  1  write data: 0 = ALUOut, 1 = MDR
- reg_write  out  1  register file write enable
- instr_done  out  1  one-cycle pulse in each instruction's final state
- illegal  out  1  one-cycle pulse in DECODE when opcode or funct is unsupported

Behaviour:
- State register: synchronous reset. While rst_n = 0 at a rising edge, state <= RESET.
- RESET asserts no outputs: every output is 0, including alu_control = 0000.
- RESET -> FETCH unconditionally on the next edge with rst_n = 1.
- Outputs are Moore, decoded combinationally from the state. The single exception is pc_en = pc_write | (pc_write_cond & zero).
- Any output not listed for a state is 0.
- ALU encodings: add 0010, sub 0110, and 0000, or 0001, slt 0111.
- Supported instructions:
  - R-type: opcode 000000 with funct add 100000, sub 100010, and 100100, or 100101, slt 101010.
  - lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
- States, asserted outputs, and next state:
  - FETCH: mem_read, ir_write, alu_src_a = 0, alu_src_b = 1, alu_control = add, pc_source = 0, pc_write. Next: DECODE.
  - DECODE: alu_src_a = 0, alu_src_b = 3, alu_control = add (branch target into ALUOut).
    - Next: MEM_ADDR for lw/sw or addi, R_EXEC, BRANCH, or JUMP.
    - Unsupported opcode, or R-type with unsupported funct: assert illegal and go to FETCH. No register or memory write occurs.
  - MEM_ADDR: alu_src_a = 1, alu_src_b = 2, alu_control = add. Next: MEM_READ (lw), MEM_WRITE (sw), ADDI_WB (addi).
  - MEM_READ: mem_read, i_or_d = 1. Next: MEM_WB.
  - MEM_WB: reg_write, reg_dst = 0, mem_to_reg = 1, instr_done. Next: FETCH.
  - MEM_WRITE: mem_write, i_or_d = 1, instr_done. Next: FETCH.
  - R_EXEC: alu_src_a = 1, alu_src_b = 0, alu_control from funct. Next: R_WB.
  - R_WB: reg_write, reg_dst = 1, mem_to_reg = 0, instr_done. Next: FETCH.
  - ADDI_WB: reg_write, reg_dst = 0, mem_to_reg = 0, instr_done. Next: FETCH.
  - BRANCH: alu_src_a = 1, alu_src_b = 0, alu_control = sub, pc_source = 1, pc_write_cond, instr_done. Next: FETCH.
  - JUMP: pc_source = 2, pc_write, instr_done. Next: FETCH.
- Latency in cycles, FETCH through the final state: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- opcode and funct are sampled only in DECODE and R_EXEC. The instruction register holds them stable from the cycle after FETCH.
- alu_control in R_EXEC is decoded from funct each cycle. An unreachable funct value gives alu_control = 0000.
- Unused or illegal state encodings -> FETCH on the next edge, with all outputs 0 while in that state.
- Reset mid-instruction: the next edge with rst_n = 0 forces RESET regardless of state. No write strobe (mem_write, reg_write, pc_en) may be asserted in the cycle after that edge.
- rst_n sampled low for several cycles: stay in RESET.
- beq with zero = 1: pc_en = 1 in BRANCH. With zero = 0: pc_en = 0.

Test Plan:
- Reset and fetch: rst_n low for 2 cycles, then high, opcode = 000000, funct = 100000.
  - Required: all outputs 0 during reset.
  - Next cycle FETCH: mem_read = ir_write = pc_en = 1, alu_control = 0010, alu_src_b = 1.
- lw (opcode 100011): state sequence FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB.
  - Required: alu_src_b = 2 in MEM_ADDR; i_or_d = 1 in MEM_READ.
  - In MEM_WB: reg_write = mem_to_reg = 1, reg_dst = 0, instr_done = 1.
  - Next FETCH is on cycle 6.
- R-type sweep: funct 100000/100010/100100/100101/101010.
  - Required: alu_control in R_EXEC = 0010/0110/0000/0001/0111 respectively.
  - reg_write = reg_dst = 1 in R_WB.
- beq (000100): run once with zero = 1 and once with zero = 0 in BRANCH.
  - Required: pc_en = 1 and 0 respectively, alu_control = 0110, pc_source = 1.
  - Total 3 cycles.
- Illegal decode: opcode 111111, then opcode 000000 with funct 000111.
  - Required: illegal = 1 for one cycle in DECODE, then FETCH.
  - reg_write, mem_write and instr_done never asserted.
- Reset mid-instruction: sw, with rst_n driven low during MEM_ADDR.
  - Required: RESET on the next edge, mem_write never asserted.
  - FETCH resumes the cycle after rst_n returns high.
